// File: rtl/mc_processor.sv
// Multi-cycle MIPS-subset core with a single shared instruction/data memory
// port. The memory may stretch any access with wait states via mem_ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | request instruction at PC, latch IR, PC += 4
// S_DECODE | read rs/rt into A/B, resolve j, reject unsupported encodings
// S_EXEC   | ALU op, effective address + alignment check, beq resolution
// S_MEM    | data access for lw/sw, held until mem_ready
// S_WB     | register-file write (rd for R-type, rt for addi/lw)
// S_HALT   | stopped, no requests, PC frozen; only reset leaves
module mc_processor #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [31:0]       alu_out;
    logic [31:0]       mdr;
    logic [31:0]       rf [32];

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [31:0]       imm_sext;
    logic [31:0]       alu_y;
    logic [31:0]       pc32;
    logic [31:0]       j_full;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] eff_addr;
    logic [4:0]        wb_dest;
    logic [31:0]       wb_data;
    logic              rtype_ok;
    logic              supported;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    // The all-zero word (sll $0,$0,0) is the only shift accepted, as a NOP.
    assign rtype_ok  = (ir == 32'h0) || (funct == F_ADD) || (funct == F_SUB) ||
                       (funct == F_AND) || (funct == F_OR) || (funct == F_SLT);
    assign supported = ((opcode == OP_R) && rtype_ok) || (opcode == OP_J) ||
                       (opcode == OP_BEQ) || (opcode == OP_ADDI) ||
                       (opcode == OP_LW) || (opcode == OP_SW);

    // Jump keeps the upper PC bits (of PC+4) only when the address space reaches bit 28.
    assign pc32      = 32'(pc);
    assign j_full    = {pc32[31:28], ir[25:0], 2'b00};
    assign j_target  = ADDR_W'(j_full);
    assign br_target = pc + {imm_sext[ADDR_W-3:0], 2'b00};
    assign eff_addr  = alu_y[ADDR_W-1:0];

    assign wb_dest = (opcode == OP_R)  ? rd  : rt;
    assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

    assign pc_out = pc;

    // ALU: R-type ops select on funct, everything else is base + sign-extended imm.
    always_comb begin
        alu_y = a_reg + imm_sext;
        if (opcode == OP_R) begin
            case (funct)
                F_ADD:   alu_y = a_reg + b_reg;
                F_SUB:   alu_y = a_reg - b_reg;
                F_AND:   alu_y = a_reg & b_reg;
                F_OR:    alu_y = a_reg | b_reg;
                F_SLT:   alu_y = {31'd0, $signed(a_reg) < $signed(b_reg)};
                default: alu_y = '0;
            endcase
        end
    end

    // Control FSM, datapath registers, register file and registered memory port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            halted    <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + ADDR_W'(4);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end else if (!mem_req) begin
                        // First cycle out of reset: launch the fetch.
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_DECODE: begin
                    a_reg <= rf[rs];
                    b_reg <= rf[rt];
                    if (!supported) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (opcode == OP_J) begin
                        pc       <= j_target;
                        mem_req  <= 1'b1;
                        mem_addr <= j_target;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_y;
                    case (opcode)
                        OP_LW, OP_SW: begin
                            if (eff_addr[1:0] != 2'b00) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_addr <= eff_addr;
                                mem_we   <= (opcode == OP_SW);
                                if (opcode == OP_SW) mem_wdata <= b_reg;
                                state    <= S_MEM;
                            end
                        end
                        OP_BEQ: begin
                            if (a_reg == b_reg) begin
                                pc       <= br_target;
                                mem_addr <= br_target;
                            end else begin
                                mem_addr <= pc;
                            end
                            mem_req <= 1'b1;
                            state   <= S_FETCH;
                        end
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_req && mem_ready) begin
                        mem_we <= 1'b0;
                        if (opcode == OP_SW) begin
                            // Store done: the next fetch request follows back to back.
                            mem_addr <= pc;
                            state    <= S_FETCH;
                        end else begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dest != 5'd0) rf[wb_dest] <= wb_data;
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_processor.sv
// Bench for mc_processor: memory responder with configurable wait states,
// ISA-level reference interpreter, directed programs plus random programs.
module tb_mc_processor;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ready = 1'b0;
    logic              halted;
    logic [ADDR_W-1:0] pc_out;

    always #5 clk = ~clk;

    mc_processor #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc_out    (pc_out)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    acc_t        act_q[$];
    acc_t        exp_q[$];
    logic [31:0] mem   [64];
    logic [31:0] m_mem [64];
    logic [31:0] m_regs[32];
    logic [7:0]  m_pc;
    logic        m_halted;
    int          m_cycles;

    int tests = 0;
    int fails = 0;
    int wait_mode = 0;
    int cyc = 0;
    int c0 = 0;
    int halt_cyc = 0;
    bit got_c0 = 0;
    bit got_halt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] a);
        return {6'h02, a};
    endfunction

    function automatic int pick_wait();
        if (wait_mode == 0) return 0;
        if (wait_mode == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    // Memory responder: one access per request, ready after the chosen number
    // of wait cycles; request attributes must hold while waiting.
    initial begin : responder
        bit          busy;
        int          cnt;
        logic [7:0]  l_addr;
        logic        l_we;
        logic [31:0] l_wd;
        int          l_start;
        busy = 0;
        cnt = 0;
        l_addr = 8'h0;
        l_we = 1'b0;
        l_wd = 32'h0;
        l_start = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mem_ready = 1'b0;
                busy = 0;
                cyc = 0;
                got_c0 = 0;
                got_halt = 0;
            end else begin
                cyc++;
                if (mem_req && !got_c0) begin
                    got_c0 = 1;
                    c0 = cyc;
                end
                if (halted && !got_halt) begin
                    got_halt = 1;
                    halt_cyc = cyc;
                end
                if (!mem_req) begin
                    mem_ready = 1'b0;
                    busy = 0;
                end else begin
                    if (!busy) begin
                        busy = 1;
                        cnt = pick_wait();
                        l_addr = mem_addr;
                        l_we = mem_we;
                        l_wd = mem_wdata;
                        l_start = cyc - c0;
                    end else begin
                        check("stable mem_addr", 32'(mem_addr), 32'(l_addr));
                        check("stable mem_we", 32'(mem_we), 32'(l_we));
                        check("stable mem_wdata", mem_wdata, l_wd);
                    end
                    if (cnt == 0) begin
                        mem_ready = 1'b1;
                        busy = 0;
                        if (l_we) begin
                            mem[l_addr[7:2]] = l_wd;
                            act_q.push_back('{1'b1, l_addr, l_wd, l_start});
                        end else begin
                            mem_rdata = mem[l_addr[7:2]];
                            act_q.push_back('{1'b0, l_addr, 32'h0, l_start});
                        end
                    end else begin
                        mem_ready = 1'b0;
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_regs[r] = v;
    endtask

    // Instruction-level interpreter: produces the expected bus access list,
    // the start cycle of each access with zero-wait memory, final PC and halt.
    task automatic model_run();
        logic [31:0] ir, a, b, imm, ea32;
        logic [7:0]  pc, ea;
        int          cm;
        bit          done;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        exp_q.delete();
        pc = 8'h00;
        cm = 0;
        done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            exp_q.push_back('{1'b0, pc, 32'h0, cm});
            ir  = m_mem[pc[7:2]];
            pc  = pc + 8'd4;
            a   = m_regs[ir[25:21]];
            b   = m_regs[ir[20:16]];
            imm = {{16{ir[15]}}, ir[15:0]};
            case (ir[31:26])
                6'h00: begin
                    if (ir == 32'h0) cm += 4;
                    else begin
                        case (ir[5:0])
                            6'h20: set_reg(ir[15:11], a + b);
                            6'h22: set_reg(ir[15:11], a - b);
                            6'h24: set_reg(ir[15:11], a & b);
                            6'h25: set_reg(ir[15:11], a | b);
                            6'h2A: set_reg(ir[15:11], 32'($signed(a) < $signed(b)));
                            default: done = 1;
                        endcase
                        cm += done ? 2 : 4;
                    end
                end
                6'h08: begin
                    set_reg(ir[20:16], a + imm);
                    cm += 4;
                end
                6'h23, 6'h2B: begin
                    ea32 = a + imm;
                    ea = ea32[7:0];
                    if (ea % 4 != 0) begin
                        done = 1;
                        cm += 3;
                    end else if (ir[31:26] == 6'h23) begin
                        exp_q.push_back('{1'b0, ea, 32'h0, cm + 3});
                        set_reg(ir[20:16], m_mem[ea[7:2]]);
                        cm += 5;
                    end else begin
                        exp_q.push_back('{1'b1, ea, b, cm + 3});
                        m_mem[ea[7:2]] = b;
                        cm += 4;
                    end
                end
                6'h04: begin
                    if (a == b) pc = 8'(32'(pc) + imm * 4);
                    cm += 3;
                end
                6'h02: begin
                    pc = 8'({6'd0, ir[25:0]} * 32'd4);
                    cm += 2;
                end
                default: begin
                    done = 1;
                    cm += 2;
                end
            endcase
        end
        m_pc = pc;
        m_halted = done;
        m_cycles = cm;
    endtask

    task automatic run_prog(input string name, input int mode, input bit chk_cyc);
        int k;
        @(negedge clk);
        #2 reset_n = 1'b0;
        wait_mode = mode;
        act_q.delete();
        for (int i = 0; i < 64; i++) m_mem[i] = mem[i];
        model_run();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        k = 0;
        while (!halted && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({name, " halted"}, 32'(halted), 32'(m_halted));
        repeat (4) @(negedge clk);
        check({name, " no req after halt"}, 32'(mem_req), 32'h0);
        check({name, " pc frozen"}, 32'(pc_out), 32'(m_pc));
        check({name, " halted sticky"}, 32'(halted), 32'h1);
        check({name, " access count"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s acc%0d we", name, i), 32'(act_q[i].we), 32'(exp_q[i].we));
            check($sformatf("%s acc%0d addr", name, i), 32'(act_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s acc%0d wdata", name, i), act_q[i].data, exp_q[i].data);
            if (chk_cyc)
                check($sformatf("%s acc%0d cycle", name, i), 32'(act_q[i].cyc), 32'(exp_q[i].cyc));
        end
        if (chk_cyc) check({name, " halt cycle"}, 32'(halt_cyc - c0), 32'(m_cycles));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    initial begin : main
        logic [5:0] functs [5];
        int         n, k, found, nw;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Reset values while reset_n is low.
        #12;
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset mem_we", 32'(mem_we), 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        check("reset pc", 32'(pc_out), 32'h0);

        // Zero-wait arithmetic sequence.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'h00C0);
        mem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h00C4);
        mem[6] = 32'hFC000000;
        run_prog("alu", 0, 1);
        check("alu $3 stored", mem[48], 32'd2);
        check("alu $4 stored", mem[49], 32'd1);
        if (act_q.size() > 3) check("4th fetch cycle", 32'(act_q[3].cyc), 32'd12);
        else check("4th fetch present", 32'(act_q.size()), 32'd4);

        // Three wait states per access: sw then lw through address 0x10.
        clear_mem();
        mem[0]  = enc_j(26'h10);
        mem[16] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        mem[17] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0010);
        mem[18] = enc_i(6'h23, 5'd0, 5'd5, 16'h0010);
        mem[19] = enc_i(6'h2B, 5'd0, 5'd5, 16'h00C8);
        mem[20] = 32'hFC000000;
        run_prog("waits", 1, 0);
        found = -1;
        for (int i = 0; i < act_q.size(); i++)
            if (act_q[i].we && found < 0) found = i;
        if (found >= 0) begin
            check("first store addr", 32'(act_q[found].addr), 32'h10);
            check("first store data", act_q[found].data, 32'd2);
        end else check("first store present", 32'(found), 32'd0);
        check("lw $5 stored", mem[50], 32'd2);

        // beq not taken then taken, j to 0xFC and wrap to 0x00.
        clear_mem();
        mem[0]  = enc_i(6'h08, 5'd7, 5'd7, 16'd1);
        mem[1]  = enc_i(6'h08, 5'd0, 5'd6, 16'd2);
        mem[2]  = enc_i(6'h04, 5'd7, 5'd6, 16'd1);
        mem[3]  = enc_j(26'h3F);
        mem[4]  = enc_i(6'h2B, 5'd0, 5'd7, 16'h00C0);
        mem[5]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h00C4);
        mem[6]  = 32'hFC000000;
        mem[63] = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
        run_prog("branch", 0, 1);
        check("loop count stored", mem[48], 32'd2);
        check("0xFC instr ran", mem[49], 32'd9);
        found = -1;
        for (int i = 0; i + 1 < act_q.size(); i++)
            if (act_q[i].addr == 8'hFC && !act_q[i].we && found < 0) found = i;
        if (found >= 0) check("fetch after 0xFC", 32'(act_q[found + 1].addr), 32'h0);
        else check("fetch of 0xFC present", 32'(found), 32'd0);

        // Unsupported opcode halts after DECODE.
        clear_mem();
        mem[0] = 32'hFC000000;
        run_prog("bad opcode", 0, 1);
        check("bad opcode pc", 32'(pc_out), 32'd4);
        check("bad opcode cycles", 32'(halt_cyc - c0), 32'd2);

        // Misaligned lw halts after EXEC without a data access.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0011);
        mem[1] = enc_i(6'h23, 5'd1, 5'd2, 16'h0000);
        run_prog("misaligned", 0, 1);
        check("misaligned pc", 32'(pc_out), 32'd8);
        check("misaligned cycles", 32'(halt_cyc - c0), 32'd7);
        check("misaligned accesses", 32'(act_q.size()), 32'd2);

        // Writes to $0 are dropped.
        clear_mem();
        mem[0]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        mem[1]  = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
        mem[2]  = enc_i(6'h2B, 5'd0, 5'd6, 16'h00C0);
        mem[3]  = enc_i(6'h2B, 5'd0, 5'd0, 16'h00C4);
        mem[4]  = 32'hFC000000;
        mem[48] = 32'hDEADBEEF;
        mem[49] = 32'h00001234;
        run_prog("r0", 0, 1);
        check("$6 stored", mem[48], 32'h0);
        check("$0 stored", mem[49], 32'h0);

        // Reset while a store waits on memory.
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
        mem[2] = 32'hFC000000;
        wait_mode = 1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        act_q.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        k = 0;
        while (!(mem_req && mem_we) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("sw request seen", 32'(mem_req && mem_we), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort mem_req", 32'(mem_req), 32'h0);
        check("abort mem_we", 32'(mem_we), 32'h0);
        check("abort mem_addr", 32'(mem_addr), 32'h0);
        check("abort mem_wdata", mem_wdata, 32'h0);
        check("abort pc", 32'(pc_out), 32'h0);
        nw = 0;
        foreach (act_q[i]) if (act_q[i].we) nw++;
        check("abort no write", 32'(nw), 32'h0);
        check("abort mem untouched", mem[16], 32'h0);
        mem[0]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h00C0);
        mem[1]  = 32'hFC000000;
        mem[2]  = 32'h0;
        mem[48] = 32'hDEADBEEF;
        run_prog("restart", 1, 0);
        check("regs cleared by reset", mem[48], 32'h0);

        // Random programs: seed registers, random ops, dump registers, halt.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            n = 0;
            for (int i = 1; i < 8; i++) begin
                mem[n] = enc_i(6'h08, 5'd0, 5'(i), 16'($urandom));
                n++;
            end
            for (int i = 0; i < 10; i++) begin
                case ($urandom_range(0, 8))
                    0: mem[n] = enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                      16'($urandom));
                    6: mem[n] = enc_i(6'h23, 5'd0, 5'($urandom_range(0, 7)),
                                      16'(32'h80 + 4 * $urandom_range(0, 15)));
                    7: mem[n] = enc_i(6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                      16'd1);
                    8: mem[n] = enc_i(6'h2B, 5'd0, 5'($urandom_range(0, 7)),
                                      16'(32'h80 + 4 * $urandom_range(0, 15)));
                    default: mem[n] = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                            5'($urandom_range(0, 7)), functs[$urandom_range(0, 4)]);
                endcase
                n++;
            end
            for (int i = 1; i < 8; i++) begin
                mem[n] = enc_i(6'h2B, 5'd0, 5'(i), 16'(32'hC0 + 4 * i));
                n++;
            end
            mem[n] = 32'hFC000000;
            run_prog($sformatf("rand%0d", r), (r % 3 == 0) ? 0 : 2, (r % 3 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_processor.md
Name: mc_processor

Overview:
- Multi-cycle successor to the single-cycle MIPS core.
- Uses one unified instruction/data memory port with a req/ready handshake, so memory may insert any number of wait states.
- An internal FSM sequences FETCH/DECODE/EXEC/MEM/WB; CPI depends on the instruction class.
- Address width and reset vector are parametrised; the register file (32x32) and ALU are internal.

Parameters:
- ADDR_W, 8, byte-address width of mem_addr; PC and all addresses are modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  ADDR_W  byte address (word-aligned).
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes on the rising edge where mem_req and mem_ready are both 1.
- halted  out  1  core stopped (sticky until reset).
- pc_out  out  ADDR_W  current PC, for debug.

Behaviour:
- Reset (reset_n=0, async):
  - state=FETCH, PC=RESET_PC, all 32 registers=0.
  - mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0, halted=0.
  - Outputs are forced to these values while reset_n=0. An access in flight is abandoned and is never retried.
- Handshake:
  - mem_req=1 only in FETCH and MEM.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - The FSM leaves FETCH/MEM only on the edge where mem_ready=1; mem_rdata is captured on that edge.
  - mem_ready is ignored while mem_req=0.
- FETCH: mem_addr=PC, mem_we=0. On ready: IR<=mem_rdata, PC<=PC+4 (wraps) -> DECODE.
- DECODE: read rs and rt into A and B; sign-extend imm16.
  - j: PC <= {PC[ADDR_W-1:28 if ADDR_W>28], addr26, 2'b00} truncated to ADDR_W -> FETCH.
  - Unsupported opcode or funct -> HALT.
  - Otherwise -> EXEC.
- EXEC:
  - R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex): ALU result -> WB.
  - addi: A + sext(imm) -> WB.
  - lw/sw: A + sext(imm); if the address (truncated to ADDR_W) has bits [1:0]!=0 -> HALT, else -> MEM.
  - beq: if A==B then PC <= PC + (sext(imm)<<2), wrapping; -> FETCH.
- MEM:
  - sw: mem_we=1, mem_wdata=B; on ready -> FETCH.
  - lw: mem_we=0; on ready: MDR<=mem_rdata -> WB.
- WB:
  - Destination is rd (R-type) or rt (addi/lw).
  - Writes to $0 are discarded; $0 always reads 0.
  - -> FETCH.
- HALT: halted=1, mem_req=0, PC frozen. Only reset exits HALT.
- Instruction 0x00000000 (sll $0,$0,0) is a NOP: it takes the R-type path with no register write. No other shifts are supported (-> HALT).
- Arithmetic: 32-bit two's complement, overflow ignored (add behaves like addu). slt is a signed compare.
- Cycle counts with zero-wait memory (mem_ready tied high):
  - R-type/addi: 4. lw: 5. sw: 4. beq: 3. j: 2.
  - Each wait cycle adds 1 cycle per access.
- Register read in DECODE observes any write committed in the previous instruction's WB.

Test Plan:
- Zero-wait, mem_ready=1: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1; fetch of the 4th instruction starts at cycle 12.
- Wait-state memory (ready after 3 cycles): sw $3,16($0) then lw $5,16($0) -> write at addr 0x10 with wdata=2; mem_addr/we/wdata stable during every wait; $5=2.
- beq taken and not taken, plus a PC wrap with ADDR_W=8: j to 0xFC followed by sequential fetch -> next fetch address 0x00.
- Unsupported opcode 0xFC000000, and lw to address 0x11 -> halted=1 after DECODE/EXEC respectively; mem_req stays 0; PC frozen.
- Write to $0 (addi $0,$0,7) then add $6,$0,$0 -> $6=0.
- reset_n pulsed low while MEM is waiting on sw -> mem_req drops immediately, no write is performed, fetch restarts at RESET_PC with registers=0.
